myla_capture_ctl: RTL and testbench
===================================

Name: myla_capture_ctl

Overview:
- Capture sequencer placed in front of the MYLA sample queue. It owns the queue's CHAN_I/GATE_I inputs.
- Divides the clock into sample ticks, waits for an armed trigger pattern, then gates a programmed number of post-trigger samples into the queue.
- Configured and polled by the CPU through its own single-cycle Wishbone slave, decoded next to the MYLA.

Parameters:
- DBITS, 8, channel/sample width; also the Wishbone data width.
- CBITS, 8, width of the divider, count and captured-count registers (CBITS <= DBITS).

Ports:
- CLK_I  in  1  system clock.
- RES_I  in  1  reset, asynchronous, active-low.
- ADR_I  in  3  register select.
- WE_I  in  1  write enable.
- CYC_I  in  1  bus cycle.
- STB_I  in  1  strobe.
- DAT_I  in  DBITS  write data.
- ACK_O  out  1  acknowledge.
- DAT_O  out  DBITS  read data.
- PROBE_I  in  DBITS  raw channel inputs.
- QFULL_I  in  1  queue-full flag from MYLA status.
- CHAN_O  out  DBITS  sample to MYLA CHAN_I.
- GATE_O  out  1  push strobe to MYLA GATE_I.

Behaviour:
- Reset (RES_I low, async):
  - state=IDLE; CHAN_O=0; GATE_O=0; OVF=0.
  - MASK=0, VALUE=0, DIV=0, COUNT=0, CAPTURED=0, prescaler=0.
- Bus:
  - ACK_O = CYC_I & STB_I, combinational; every access is a single cycle.
  - DAT_O is combinational from ADR_I. Unused bits read 0; reads of undefined addresses return 0.
  - Writes take effect on the CLK_I edge where CYC_I & STB_I & WE_I.
- Register map:
  - 0 CTRL: write bit0=ARM, bit1=ABORT; read returns state code.
  - 1 STAT, read-only: bit0 ARMED, bit1 CAPTURING, bit2 DONE, bit3 OVF.
  - 2 MASK.
  - 3 VALUE.
  - 4 DIV.
  - 5 COUNT (0 = capture until queue full or abort).
  - 6 CAPTURED, read-only.
- Config writes (2–5) are accepted only in IDLE or DONE. They are ignored in ARMED and CAPTURE.
- Prescaler:
  - tick = (prescaler==0).
  - On tick, prescaler reloads DIV; otherwise it decrements.
  - DIV=0 gives a tick every cycle; DIV=n gives a tick every n+1 cycles.
  - An ARM write forces prescaler=0, so the first tick is the cycle after arming.
- Trigger match (combinational): ((PROBE_I ^ VALUE) & MASK)==0. MASK=0 triggers on the first tick.
- State machine, codes IDLE=0, ARMED=1, CAPTURE=2, DONE=3:
  - IDLE/DONE + ARM write → ARMED; clears CAPTURED and OVF.
  - ARMED + tick + match → CAPTURE. The same edge loads CHAN_O<=PROBE_I, GATE_O<=1, CAPTURED<=1. The trigger sample is always stored.
    - If QFULL_I is high at that tick: no push, go to DONE, OVF=1.
    - If COUNT==1: go straight to DONE after this push.
  - CAPTURE + tick:
    - QFULL_I high → no push, DONE, OVF=1.
    - Otherwise push (CHAN_O<=PROBE_I, GATE_O<=1, CAPTURED+1).
    - If the new CAPTURED==COUNT and COUNT!=0 → DONE.
  - COUNT=0: capture continues until QFULL_I or ABORT. CAPTURED saturates at 2^CBITS-1.
  - Any state + ABORT write → IDLE; GATE_O<=0 on that edge. ABORT wins over ARM in the same write.
  - ARM in ARMED or CAPTURE is ignored.
- GATE_O:
  - High for exactly one cycle per stored sample; never high in IDLE, ARMED or DONE except on the trigger edge.
  - CHAN_O holds its last value between pushes.
- Latency: probe value at a tick edge → CHAN_O/GATE_O valid in the following cycle → MYLA stores it on the next edge.
- Reset mid-capture aborts immediately; there is no further GATE_O.

Decomposition:
- Shared package/include (myla.vh) gains:
  - register addresses MYLA_CTL_CTRL..MYLA_CTL_CAPTURED;
  - state codes;
  - STAT bit positions;
  - CTRL bit positions ARM/ABORT.
- One natural sub-module: myla_prescaler, holding the DIV reload counter and producing tick, with a sync clear on ARM.

Test Plan:
1. Reset, then read STAT and CTRL → ACK_O=1 in the same cycle; STAT=0; CTRL=0 (IDLE); GATE_O=0.
2. MASK=0xFF, VALUE=0x5A, DIV=0, COUNT=3, ARM; drive PROBE_I 0x11, 0x5A, 0x01, 0x02, 0x03 on consecutive cycles → GATE_O pulses on 3 consecutive cycles with CHAN_O=0x5A, 0x01, 0x02; STAT=DONE; CAPTURED=3.
3. MASK=0, DIV=3, COUNT=4, ARM, PROBE_I incrementing each cycle → GATE_O pulses exactly every 4 cycles, 4 pulses total, then DONE.
4. COUNT=0, MASK=0, DIV=0, with a real MYLA (QBITS=4) attached → 15 pushes, then QFULL_I stops capture; STAT=DONE|OVF; CAPTURED=15; queue drains 0..14 in order.
5. ARM with an unmatched pattern, then write MASK mid-ARMED (ignored), then write CTRL=ARM|ABORT → state IDLE, MASK unchanged, no GATE_O ever asserted.
6. Assert RES_I low mid-CAPTURE between clock edges → GATE_O=0 and CHAN_O=0 immediately; STAT=0 after release.

Source files
------------

// File: rtl/myla_capture_ctl_pkg.sv
// Shared definitions for the MYLA capture sequencer: register map, state codes,
// STAT/CTRL bit positions.
package myla_capture_ctl_pkg;

   typedef logic [2:0] reg_addr_t;

   localparam reg_addr_t MYLA_CTL_CTRL     = 3'd0;
   localparam reg_addr_t MYLA_CTL_STAT     = 3'd1;
   localparam reg_addr_t MYLA_CTL_MASK     = 3'd2;
   localparam reg_addr_t MYLA_CTL_VALUE    = 3'd3;
   localparam reg_addr_t MYLA_CTL_DIV      = 3'd4;
   localparam reg_addr_t MYLA_CTL_COUNT    = 3'd5;
   localparam reg_addr_t MYLA_CTL_CAPTURED = 3'd6;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam int STAT_ARMED     = 0;
   localparam int STAT_CAPTURING = 1;
   localparam int STAT_DONE      = 2;
   localparam int STAT_OVF       = 3;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/myla_capture_ctl_if.sv
// Single-cycle Wishbone register port of the MYLA capture sequencer.
interface myla_capture_ctl_if #(
   parameter int DBITS = 8
);
   logic [2:0]       ADR_I;
   logic             WE_I;
   logic             CYC_I;
   logic             STB_I;
   logic [DBITS-1:0] DAT_I;
   logic             ACK_O;
   logic [DBITS-1:0] DAT_O;

   modport master (
      output ADR_I, WE_I, CYC_I, STB_I, DAT_I,
      input  ACK_O, DAT_O
   );

   modport slave (
      input  ADR_I, WE_I, CYC_I, STB_I, DAT_I,
      output ACK_O, DAT_O
   );
endinterface

// File: rtl/myla_prescaler.sv
// Sample-tick divider: down-counter reloaded from div on terminal count, giving one
// tick every div+1 cycles; clr forces terminal count so the next cycle ticks.
module myla_prescaler #(
   parameter int CBITS = 8
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             clr,
   input  logic [CBITS-1:0] div,
   output logic             tick
);

   logic [CBITS-1:0] cnt;

   assign tick = (cnt == '0);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= div;
      end else begin
         cnt <= cnt - CBITS'(1);
      end
   end

endmodule

// File: rtl/myla_capture_ctl.sv
// MYLA capture sequencer: waits for an armed trigger pattern on sample ticks, then
// gates post-trigger samples into the MYLA queue; configured over Wishbone.
//
// state    | meaning
// IDLE     | quiescent, config registers writable
// ARMED    | waiting for a tick where PROBE_I matches VALUE under MASK
// CAPTURE  | one push per tick until COUNT reached, queue full or abort
// DONE     | capture finished, results readable, config writable
module myla_capture_ctl
   import myla_capture_ctl_pkg::*;
#(
   parameter int DBITS = 8,
   parameter int CBITS = 8
) (
   input  logic              CLK_I,
   input  logic              RES_I,
   myla_capture_ctl_if.slave bus,
   input  logic [DBITS-1:0]  PROBE_I,
   input  logic              QFULL_I,
   output logic [DBITS-1:0]  CHAN_O,
   output logic              GATE_O
);

   logic [1:0]       state;
   logic [DBITS-1:0] mask_r;
   logic [DBITS-1:0] value_r;
   logic [CBITS-1:0] div_r;
   logic [CBITS-1:0] count_r;
   logic [CBITS-1:0] captured_r;
   logic [CBITS-1:0] captured_inc;
   logic             ovf_r;
   logic             tick;
   logic             match;
   logic             bus_wr;
   logic             ctrl_wr;
   logic             cfg_open;
   logic             abort_req;
   logic             arm_req;
   logic [DBITS-1:0] rd_data;

   assign bus_wr    = bus.CYC_I & bus.STB_I & bus.WE_I;
   assign ctrl_wr   = bus_wr & (bus.ADR_I == MYLA_CTL_CTRL);
   assign cfg_open  = (state == ST_IDLE) | (state == ST_DONE);
   assign abort_req = ctrl_wr & bus.DAT_I[CTRL_ABORT];
   assign arm_req   = ctrl_wr & bus.DAT_I[CTRL_ARM] & ~abort_req & cfg_open;

   assign match        = (((PROBE_I ^ value_r) & mask_r) == '0);
   assign captured_inc = (&captured_r) ? captured_r : captured_r + CBITS'(1);

   myla_prescaler #(.CBITS(CBITS)) u_prescaler (
      .clk_sys (CLK_I),
      .rst_b   (RES_I),
      .clr     (arm_req),
      .div     (div_r),
      .tick    (tick)
   );

   always_ff @(posedge CLK_I or negedge RES_I) begin
      if (!RES_I) begin
         mask_r  <= '0;
         value_r <= '0;
         div_r   <= '0;
         count_r <= '0;
      end else if (bus_wr && cfg_open) begin
         case (bus.ADR_I)
            MYLA_CTL_MASK:  mask_r  <= bus.DAT_I;
            MYLA_CTL_VALUE: value_r <= bus.DAT_I;
            MYLA_CTL_DIV:   div_r   <= bus.DAT_I[CBITS-1:0];
            MYLA_CTL_COUNT: count_r <= bus.DAT_I[CBITS-1:0];
            default: ;
         endcase
      end
   end

   // A full queue on a would-be push ends the capture without storing that sample.
   always_ff @(posedge CLK_I or negedge RES_I) begin
      if (!RES_I) begin
         state      <= ST_IDLE;
         CHAN_O     <= '0;
         GATE_O     <= 1'b0;
         captured_r <= '0;
         ovf_r      <= 1'b0;
      end else begin
         GATE_O <= 1'b0;
         if (abort_req) begin
            state <= ST_IDLE;
         end else if (arm_req) begin
            state      <= ST_ARMED;
            captured_r <= '0;
            ovf_r      <= 1'b0;
         end else if (tick) begin
            case (state)
               ST_ARMED: begin
                  if (match) begin
                     if (QFULL_I) begin
                        state <= ST_DONE;
                        ovf_r <= 1'b1;
                     end else begin
                        CHAN_O     <= PROBE_I;
                        GATE_O     <= 1'b1;
                        captured_r <= CBITS'(1);
                        state      <= (count_r == CBITS'(1)) ? ST_DONE : ST_CAPTURE;
                     end
                  end
               end
               ST_CAPTURE: begin
                  if (QFULL_I) begin
                     state <= ST_DONE;
                     ovf_r <= 1'b1;
                  end else begin
                     CHAN_O     <= PROBE_I;
                     GATE_O     <= 1'b1;
                     captured_r <= captured_inc;
                     if ((count_r != '0) && (captured_inc == count_r)) begin
                        state <= ST_DONE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ACK_O = bus.CYC_I & bus.STB_I;
   assign bus.DAT_O = rd_data;

   always_comb begin
      rd_data = '0;
      case (bus.ADR_I)
         MYLA_CTL_CTRL:  rd_data[1:0] = state;
         MYLA_CTL_STAT: begin
            rd_data[STAT_ARMED]     = (state == ST_ARMED);
            rd_data[STAT_CAPTURING] = (state == ST_CAPTURE);
            rd_data[STAT_DONE]      = (state == ST_DONE);
            rd_data[STAT_OVF]       = ovf_r;
         end
         MYLA_CTL_MASK:     rd_data = mask_r;
         MYLA_CTL_VALUE:    rd_data = value_r;
         MYLA_CTL_DIV:      rd_data[CBITS-1:0] = div_r;
         MYLA_CTL_COUNT:    rd_data[CBITS-1:0] = count_r;
         MYLA_CTL_CAPTURED: rd_data[CBITS-1:0] = captured_r;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_myla_capture_ctl.sv
// Bench for myla_capture_ctl: directed scenarios plus randomized runs against a
// cycle-level behavioural model of the capture rules.
module tb_myla_capture_ctl;

   logic       clk_sys = 1'b0;
   logic       rst_b;
   logic [7:0] probe;
   logic       qfull;
   logic [7:0] chan;
   logic       gate;

   myla_capture_ctl_if #(.DBITS(8)) bus ();

   myla_capture_ctl #(.DBITS(8), .CBITS(8)) dut (
      .CLK_I   (clk_sys),
      .RES_I   (rst_b),
      .bus     (bus),
      .PROBE_I (probe),
      .QFULL_I (qfull),
      .CHAN_O  (chan),
      .GATE_O  (gate)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // behavioural model: state 0 idle, 1 armed, 2 capture, 3 done
   int         m_state;
   int         m_k;
   logic [7:0] m_mask, m_value, m_div, m_count, m_cap, m_chan;
   bit         m_ovf, m_gate;

   // stand-in for the MYLA queue (15 usable entries)
   logic [7:0] fifo_q[$];
   bit         fifo_en = 0;

   task automatic model_reset();
      m_state = 0; m_k = 0; m_mask = 0; m_value = 0; m_div = 0; m_count = 0;
      m_cap = 0; m_chan = 0; m_ovf = 0; m_gate = 0;
   endtask

   task automatic model_edge();
      bit wr;
      int st;
      wr = bus.CYC_I && bus.STB_I && bus.WE_I;
      st = m_state;
      m_gate = 0;
      if (wr && (st == 0 || st == 3)) begin
         case (bus.ADR_I)
            3'd2: m_mask  = bus.DAT_I;
            3'd3: m_value = bus.DAT_I;
            3'd4: m_div   = bus.DAT_I;
            3'd5: m_count = bus.DAT_I;
            default: ;
         endcase
      end
      if (wr && bus.ADR_I == 3'd0 && bus.DAT_I[1]) begin
         m_state = 0;
      end else if (wr && bus.ADR_I == 3'd0 && bus.DAT_I[0] && (st == 0 || st == 3)) begin
         m_state = 1; m_cap = 0; m_ovf = 0; m_k = 0;
      end else if (st == 1 || st == 2) begin
         m_k++;
         if (((m_k - 1) % (int'(m_div) + 1)) == 0) begin
            if (st == 1 && ((probe ^ m_value) & m_mask) != 8'h00) begin
               m_state = 1;
            end else if (qfull) begin
               m_state = 3; m_ovf = 1;
            end else begin
               m_gate = 1;
               m_chan = probe;
               if (st == 1) m_cap = 1;
               else if (m_cap != 8'hFF) m_cap = m_cap + 8'd1;
               m_state = (m_count != 0 && m_cap == m_count) ? 3 : 2;
            end
         end
      end
   endtask

   function automatic logic [7:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return 8'(m_state);
         3'd1: return {4'b0, m_ovf, m_state == 3, m_state == 2, m_state == 1};
         3'd2: return m_mask;
         3'd3: return m_value;
         3'd4: return m_div;
         3'd5: return m_count;
         3'd6: return m_cap;
         default: return 8'h00;
      endcase
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk_sys);
      #1;
      chk("gate", gate, m_gate);
      chk("chan", chan, m_chan);
      if (fifo_en) begin
         if (gate) fifo_q.push_back(chan);
         qfull = (fifo_q.size() >= 15);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      bus.ADR_I = a; bus.DAT_I = d; bus.WE_I = 1; bus.CYC_I = 1; bus.STB_I = 1;
      step();
      bus.WE_I = 0; bus.CYC_I = 0; bus.STB_I = 0;
   endtask

   task automatic bus_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
      bus.ADR_I = a; bus.WE_I = 0; bus.CYC_I = 1; bus.STB_I = 1;
      #1;
      chk({tag, "_ack"}, bus.ACK_O, 1);
      chk(tag, bus.DAT_O, exp);
      bus.CYC_I = 0; bus.STB_I = 0;
      #1;
      chk({tag, "_ack_idle"}, bus.ACK_O, 0);
   endtask

   initial begin
      int gcount;
      int idx[$];
      logic [7:0] pv;
      logic [2:0] ra;

      rst_b = 0; probe = 0; qfull = 0;
      bus.ADR_I = 0; bus.DAT_I = 0; bus.WE_I = 0; bus.CYC_I = 0; bus.STB_I = 0;
      model_reset();
      repeat (2) @(posedge clk_sys);
      #1 rst_b = 1;

      // 1: reset state
      bus_read("t1_stat", 3'd1, 8'h00);
      bus_read("t1_ctrl", 3'd0, 8'h00);
      chk("t1_gate", gate, 0);
      chk("t1_chan", chan, 0);

      // 2: exact pattern, COUNT=3
      bus_write(3'd2, 8'hFF); bus_write(3'd3, 8'h5A);
      bus_write(3'd4, 8'h00); bus_write(3'd5, 8'h03);
      bus_write(3'd0, 8'h01);
      gcount = 0;
      foreach (idx[i]) idx.delete(i);
      begin
         logic [7:0] seq [5] = '{8'h11, 8'h5A, 8'h01, 8'h02, 8'h03};
         logic [7:0] expc[3] = '{8'h5A, 8'h01, 8'h02};
         for (int i = 0; i < 5; i++) begin
            probe = seq[i];
            step();
            if (gate) begin
               if (gcount < 3) chk("t2_chan", chan, expc[gcount]);
               gcount++;
               idx.push_back(i);
            end
         end
      end
      chk("t2_pulses", gcount, 3);
      chk("t2_first", idx[0], 1);
      chk("t2_consec", idx[2] - idx[0], 2);
      bus_read("t2_stat", 3'd1, 8'h04);
      bus_read("t2_captured", 3'd6, 8'h03);

      // 3: DIV=3, COUNT=4, free trigger
      bus_write(3'd2, 8'h00); bus_write(3'd4, 8'h03); bus_write(3'd5, 8'h04);
      bus_write(3'd0, 8'h01);
      idx.delete();
      for (int i = 1; i <= 20; i++) begin
         probe = 8'(i);
         step();
         if (gate) idx.push_back(i);
      end
      chk("t3_pulses", idx.size(), 4);
      if (idx.size() == 4) begin
         chk("t3_first", idx[0], 1);
         for (int i = 1; i < 4; i++) chk("t3_gap", idx[i] - idx[i-1], 4);
      end
      bus_read("t3_stat", 3'd1, 8'h04);
      bus_read("t3_captured", 3'd6, 8'h04);

      // 4: COUNT=0 into a 15-entry queue until full
      bus_write(3'd4, 8'h00); bus_write(3'd5, 8'h00);
      fifo_q.delete(); fifo_en = 1; qfull = 0;
      bus_write(3'd0, 8'h01);
      for (int i = 0; i < 100 && m_state != 3; i++) begin
         probe = 8'(i);
         step();
      end
      fifo_en = 0; qfull = 0;
      chk("t4_done", m_state, 3);
      bus_read("t4_stat", 3'd1, 8'h0C);
      bus_read("t4_captured", 3'd6, 8'd15);
      chk("t4_qsize", fifo_q.size(), 15);
      for (int i = 0; i < 15 && fifo_q.size() > 0; i++) chk("t4_drain", fifo_q.pop_front(), i);

      // 5: unmatched arm, ignored MASK write, ARM|ABORT
      bus_write(3'd0, 8'h02);
      bus_write(3'd2, 8'hFF); bus_write(3'd3, 8'hAA);
      bus_write(3'd0, 8'h01);
      gcount = 0;
      for (int i = 0; i < 20; i++) begin
         pv = 8'($urandom_range(0, 255));
         probe = (pv == 8'hAA) ? 8'h55 : pv;
         if (i == 8) bus_write(3'd2, 8'h0F); else step();
         if (gate) gcount++;
      end
      bus_read("t5_armed", 3'd0, 8'h01);
      bus_write(3'd0, 8'h03);
      bus_read("t5_ctrl", 3'd0, 8'h00);
      bus_read("t5_mask", 3'd2, 8'hFF);
      chk("t5_gates", gcount, 0);

      // randomized rounds against the model
      for (int r = 0; r < 8; r++) begin
         qfull = 0;
         bus_write(3'd0, 8'h02);
         bus_write(3'd2, 8'($urandom_range(0, 255)) & 8'h0F);
         bus_write(3'd3, 8'($urandom_range(0, 255)));
         bus_write(3'd4, 8'($urandom_range(0, 3)));
         bus_write(3'd5, 8'($urandom_range(0, 5)));
         bus_write(3'd0, 8'h01);
         for (int c = 0; c < 60; c++) begin
            int pick;
            probe = 8'($urandom_range(0, 255));
            qfull = ($urandom_range(0, 29) == 0);
            pick  = $urandom_range(0, 99);
            if (pick < 2) bus_write(3'd0, 8'h02);
            else if (pick < 5) bus_write(3'd0, 8'h01);
            else if (pick < 8) bus_write(3'($urandom_range(2, 5)), 8'($urandom_range(0, 255)));
            else step();
            if (pick >= 90) begin
               ra = 3'($urandom_range(0, 7));
               bus_read("rnd_rd", ra, m_read(ra));
            end
         end
      end
      qfull = 0;

      // 6: reset between edges while capturing
      bus_write(3'd0, 8'h02);
      bus_write(3'd2, 8'h00); bus_write(3'd4, 8'h00); bus_write(3'd5, 8'h00);
      bus_write(3'd0, 8'h01);
      for (int i = 0; i < 5; i++) begin
         probe = 8'h80 + 8'(i);
         step();
      end
      chk("t6_pre_gate", gate, 1);
      #3 rst_b = 0;
      #1;
      chk("t6_gate", gate, 0);
      chk("t6_chan", chan, 0);
      model_reset();
      repeat (2) @(posedge clk_sys);
      #1 rst_b = 1;
      bus_read("t6_stat", 3'd1, 8'h00);
      bus_read("t6_captured", 3'd6, 8'h00);
      step();
      chk("t6_gate_after", gate, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
